// File: rtl/bwt_search_ctrl.sv
// Exact-match BWT backward search: walks a packed DNA query last-base-first and narrows
// the suffix-array interval [low, high) using two OCC-table rows read per base.
module bwt_search_ctrl #(
  parameter int DEPTH      = 18,
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTHS     = 1920,
  parameter int CNT_W      = 32,
  parameter int ROW_BASES  = 896,
  parameter int BWT_LEN    = 16000,
  parameter int DOLLAR_POS = 0,
  parameter int IDX_W      = 14,
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2*MAX_LEN-1:0]    query,
  input  logic [LEN_W-1:0]        query_len,
  input  logic [4*IDX_W-1:0]      c_table,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [IDX_W-1:0]        sa_low,
  output logic [IDX_W-1:0]        sa_high,
  output logic                    rEn,
  output logic [ADDR_WIDTH-1:0]   rAddr0,
  output logic [ADDR_WIDTH-1:0]   rAddr1,
  input  logic [WIDTHS-1:0]       rData0,
  input  logic [WIDTHS-1:0]       rData1
);

  localparam int OFF_W    = $clog2(ROW_BASES);
  localparam int K_W      = $clog2(MAX_LEN);
  localparam int BASE_LSB = 4*CNT_W;
  localparam int SLACK_W  = CNT_W - IDX_W;

  if (BWT_LEN / ROW_BASES >= DEPTH) begin : g_bad_depth
    $error("BWT_LEN does not fit in DEPTH OCC rows");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;

  state_t                  r_state;
  logic [2*MAX_LEN-1:0]    r_query;
  logic [K_W-1:0]          r_k;
  logic [IDX_W-1:0]        r_low, r_high, r_occLow, r_occHigh;

  logic [IDX_W-1:0]        w_cTab [4];
  logic [IDX_W-1:0]        w_cp0 [4];
  logic [IDX_W-1:0]        w_cp1 [4];
  logic [4*SLACK_W-1:0]    w_unusedCp0, w_unusedCp1;
  logic                    w_unused;
  logic [1:0]              w_base;
  logic [IDX_W-1:0]        w_newLow, w_newHigh;
  logic                    w_empty;

  // Checkpoints only ever hold counts below BWT_LEN, so their upper bits carry nothing.
  for (genvar g = 0; g < 4; g++) begin : g_fields
    assign w_cTab[g] = c_table[IDX_W*g +: IDX_W];
    assign w_cp0[g]  = rData0[CNT_W*g +: IDX_W];
    assign w_cp1[g]  = rData1[CNT_W*g +: IDX_W];
    assign w_unusedCp0[SLACK_W*g +: SLACK_W] = rData0[CNT_W*g+IDX_W +: SLACK_W];
    assign w_unusedCp1[SLACK_W*g +: SLACK_W] = rData1[CNT_W*g+IDX_W +: SLACK_W];
  end
  assign w_unused = ^{w_unusedCp0, w_unusedCp1};

  function automatic logic [ADDR_WIDTH-1:0] rowOf(input logic [IDX_W-1:0] i);
    return ADDR_WIDTH'(i / IDX_W'(ROW_BASES));
  endfunction

  function automatic logic [OFF_W-1:0] offOf(input logic [IDX_W-1:0] i);
    return OFF_W'(i % IDX_W'(ROW_BASES));
  endfunction

  // Occ(c,i): row checkpoint plus matching bases before the offset; the '$' slot reads as A.
  function automatic logic [IDX_W-1:0] occOf(input logic [IDX_W-1:0] cp,
                                             input logic [2*ROW_BASES-1:0] bases,
                                             input logic [1:0] c,
                                             input logic [IDX_W-1:0] i);
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] cnt;
    logic [IDX_W-1:0] occ;
    off = offOf(i);
    cnt = '0;
    for (int j = 0; j < ROW_BASES; j++) begin
      if ((OFF_W'(j) < off) && (bases[2*j +: 2] == c)) cnt = cnt + 1'b1;
    end
    occ = cp + IDX_W'(cnt);
    if ((c == 2'd0) && (rowOf(i) == ADDR_WIDTH'(DOLLAR_POS / ROW_BASES)) &&
        (off > OFF_W'(DOLLAR_POS % ROW_BASES)))
      occ = occ - 1'b1;
    return occ;
  endfunction

  assign w_base    = r_query[{r_k, 1'b0} +: 2];
  assign w_newLow  = IDX_W'({1'b0, w_cTab[w_base]} + {1'b0, r_occLow});
  assign w_newHigh = IDX_W'({1'b0, w_cTab[w_base]} + {1'b0, r_occHigh});
  assign w_empty   = (w_newLow >= w_newHigh);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      rEn       <= 1'b0;
      sa_low    <= '0;
      sa_high   <= '0;
      rAddr0    <= '0;
      rAddr1    <= '0;
      r_low     <= '0;
      r_high    <= '0;
      r_k       <= '0;
      r_query   <= '0;
      r_occLow  <= '0;
      r_occHigh <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_query <= query;
            r_k     <= K_W'(query_len - 1'b1);
            r_low   <= '0;
            r_high  <= IDX_W'(BWT_LEN);
            busy    <= 1'b1;
            if (query_len == '0) begin
              done    <= 1'b1;
              found   <= 1'b1;
              sa_low  <= '0;
              sa_high <= IDX_W'(BWT_LEN);
              r_state <= S_DONE;
            end else begin
              rEn     <= 1'b1;
              rAddr0  <= rowOf('0);
              rAddr1  <= rowOf(IDX_W'(BWT_LEN));
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          rEn     <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_occLow  <= occOf(w_cp0[w_base], rData0[WIDTHS-1:BASE_LSB], w_base, r_low);
          r_occHigh <= occOf(w_cp1[w_base], rData1[WIDTHS-1:BASE_LSB], w_base, r_high);
          r_state   <= S_UPDATE;
        end
        S_UPDATE: begin
          r_low  <= w_newLow;
          r_high <= w_newHigh;
          if (w_empty || (r_k == '0)) begin
            found   <= ~w_empty;
            done    <= 1'b1;
            sa_low  <= w_newLow;
            sa_high <= w_newHigh;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k - 1'b1;
            rEn     <= 1'b1;
            rAddr0  <= rowOf(w_newLow);
            rAddr1  <= rowOf(w_newHigh);
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bwt_search_ctrl.md
# bwt_search_ctrl

Exact-match backward-search engine for the BWT aligner. It accepts one packed DNA query and walks it last-base-first. Each step reads two OCC rows from the OCC-table SRAM (dual read port, one-cycle registered read) and narrows the suffix-array interval [sa_low, sa_high). It sits directly upstream of the OCC SRAM: it drives the SRAM read port and consumes the two 1920-bit rows it returns.

## Interface
- DEPTH, 18: OCC rows in SRAM.
- ADDR_WIDTH, 5: SRAM row address width.
- WIDTHS, 1920: OCC row width.
- CNT_W, 32: checkpoint field width.
- ROW_BASES, 896: BWT bases per row; (WIDTHS-4*CNT_W)/2.
- BWT_LEN, 16000: BWT length including '$'; must be < DEPTH*ROW_BASES.
- DOLLAR_POS, 0: BWT index of '$'.
- IDX_W, 14: interval index width.
- MAX_LEN, 64: maximum query length in bases.
- LEN_W, 7: query_len width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- query  in  2*MAX_LEN  packed query; base k at [2k+1:2k], k=0 first. Encoding A=00, C=01, G=10, T=11.
- query_len  in  LEN_W  number of bases, 0..MAX_LEN.
- c_table  in  4*IDX_W  C[c] at [IDX_W*c+IDX_W-1 : IDX_W*c]; count of text chars < c including '$'. Static while busy.
- busy  out  1  high from ISSUE through DONE.
- done  out  1  one-cycle pulse in DONE.
- found  out  1  valid with done; 1 = non-empty interval.
- sa_low, sa_high  out  IDX_W each  final interval; held until next start.
- rEn  out  1  SRAM read enable.
- rAddr0, rAddr1  out  ADDR_WIDTH each  rows for low and high.
- rData0, rData1  in  WIDTHS each  rows; valid the cycle after rEn.

## Operation
- Row layout: checkpoint cp[c] at [CNT_W*c+CNT_W-1 : CNT_W*c], c=0..3. cp[c] is the count of c in BWT[0 .. row*ROW_BASES-1], excluding '$'. Base j of the row is at [4*CNT_W+2j+1 : 4*CNT_W+2j]. The '$' slot is stored as 00.
- Occ(c,i) is the count of c in BWT[0..i-1]:
  - row = i / ROW_BASES (constant divide); off = i % ROW_BASES.
  - Occ = cp[c][IDX_W-1:0] + number of row bases j < off equal to c.
  - For c=A only: subtract 1 if row == DOLLAR_POS/ROW_BASES and off > DOLLAR_POS%ROW_BASES.
- On start: latch query, query_len and k = query_len-1; set low=0, high=BWT_LEN.
- Per base c = query[k]:
  - low' = C[c] + Occ(c,low); high' = C[c] + Occ(c,high).
  - Compute sums at IDX_W+1 bits, then truncate.
- FSM states:
  - IDLE: on start, go to ISSUE; if query_len==0, go to DONE instead.
  - ISSUE: rEn=1, rAddr0=row(low), rAddr1=row(high); go to WAIT.
  - WAIT: rData valid; compute both Occ and register them; go to UPDATE.
  - UPDATE: low<=low', high<=high'.
    - If low' >= high': found<=0, go to DONE.
    - Else if k==0: found<=1, go to DONE.
    - Else k<=k-1, go to ISSUE.
  - DONE: done=1; sa_low=low, sa_high=high; go to IDLE.
- start outside IDLE is ignored. query and c_table changes after start have no effect, except c_table, which must stay static.
- rEn is 0 in every state except ISSUE; rAddr0/rAddr1 hold their last values otherwise.

## Timing
- Reset: state IDLE; busy, done, found, rEn = 0; sa_low, sa_high, rAddr0, rAddr1, low, high, k = 0.
- rst mid-search aborts to IDLE on the next edge with no done pulse. SRAM data in flight is discarded.
- Start sampled at edge 0. For a query of n bases that runs to completion, done is high in cycle 3n+1; n=0 gives cycle 1.
- Early miss at step m (1-based): done in cycle 3m+1, found=0, sa_low/sa_high = collapsed values.
- Back-to-back: next start is accepted in the IDLE cycle right after DONE.
- Boundary: i = k*ROW_BASES gives off=0, so Occ = cp only. i = BWT_LEN reads row BWT_LEN/ROW_BASES, which is < DEPTH.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, rEn never asserted.
- Setup for the next three scenarios: c_table A=1, C=4001, G=8001, T=12001; consistent OCC image.
- query_len=0, start -> done in cycle 1, found=1, sa_low=0, sa_high=16000, no rEn.
- Query "A", start -> rEn in cycle 1 with rAddr0=0, rAddr1=17; done in cycle 4; found=1; sa_low=1, sa_high=4001.
- Interval endpoint at 896 (row 1, off 0) and at 895 (row 0, off 895) -> Occ matches the golden model; A count decremented past DOLLAR_POS.
- Query whose interval empties at base 2 of 5 -> done in cycle 7, found=0. A start pulse at cycle 3 is ignored.
- rst asserted in a WAIT cycle -> next cycle all outputs 0, no done. A fresh search then completes normally.
